// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder: FSM state encoding and the
//   default operand width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADD  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_if.sv
// serial_adder_if
//   Start/busy/done handshake plus operand and result buses of the serial adder.
//   master : requester (drives start, a, b, cin; observes busy, done, results)
//   slave  : the adder itself
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );

endinterface : serial_adder_if

// File: rtl/serial_adder_fulladd.sv
// fulladd
//   Single-bit full adder cell; the only adder logic in the serial adder.
//   i_a, i_b : operand bits
//   i_c      : carry in
//   o_s      : sum bit
//   o_c      : carry out
module fulladd (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule : fulladd

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial adder: captures two WIDTH-bit operands and a carry-in on an
//   accepted start, then adds them LSB-first over WIDTH cycles through one
//   fulladd cell and a carry flop. Produces registered sum, carry-out and
//   signed overflow with a one-cycle done pulse.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of serial_adder_if (start/a/b/cin in; busy/done/sum/cout/ovf out)
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);

  localparam int               CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic w_s;
  logic w_c;
  logic w_load;
  logic w_step;
  logic w_last;

  fulladd u_fulladd (
    .i_a (r_a_sh[0]),
    .i_b (r_b_sh[0]),
    .i_c (r_carry),
    .o_s (w_s),
    .o_c (w_c)
  );

  assign w_load = (r_state == ST_IDLE) && bus.start;
  assign w_step = (r_state == ST_ADD);
  assign w_last = w_step && (r_cnt == LAST);

  // Next-state logic for the IDLE -> ADD -> DONE -> IDLE sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = ST_ADD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ADD: begin
        if (r_cnt == LAST) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_ADD;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register; busy/done are registered decodes of the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  // Operand capture, shifting datapath and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= {WIDTH{1'b0}};
      r_b_sh   <= {WIDTH{1'b0}};
      r_sum_sh <= {WIDTH{1'b0}};
      r_carry  <= 1'b0;
      r_cnt    <= {CW{1'b0}};
    end else if (w_load) begin
      r_a_sh  <= bus.a;
      r_b_sh  <= bus.b;
      r_carry <= bus.cin;
      r_cnt   <= {CW{1'b0}};
    end else if (w_step) begin
      r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_sum_sh <= {w_s, r_sum_sh[WIDTH-1:1]};
      r_carry  <= w_c;
      r_cnt    <= r_cnt + CW'(1);
    end
  end

  // Result registers: updated only on the final ADD edge, held otherwise.
  // On that edge r_carry is the carry into the MSB, so XOR with the MSB
  // carry-out gives signed overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= {WIDTH{1'b0}};
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_last) begin
      r_sum  <= {w_s, r_sum_sh[WIDTH-1:1]};
      r_cout <= w_c;
      r_ovf  <= r_carry ^ w_c;
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Scoreboard bench for serial_adder (WIDTH=8): stimulus pushes arithmetic
//   reference results, a negedge monitor pops and compares on done.
module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           due;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t q[$];

  logic [W-1:0] last_sum;
  logic         last_cout;
  logic         last_ovf;

  serial_adder_if #(.WIDTH(W)) sa_if ();

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sa_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input int due);
    exp_t r;
    int   u;
    int   sg;
    u  = int'(x) + int'(y) + int'(c);
    sg = int'($signed(x)) + int'($signed(y)) + int'(c);
    r.s   = u[W-1:0];
    r.co  = u[W];
    r.ov  = (sg > 127) || (sg < -128);
    r.due = due;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Wait for IDLE, present one request, push its reference result.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    int n;
    n = 0;
    @(negedge clk);
    while (sa_if.busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("issue_wait_idle", {31'd0, sa_if.busy}, 32'd0);
    sa_if.start = 1'b1;
    sa_if.a     = ta;
    sa_if.b     = tb;
    sa_if.cin   = tc;
    q.push_back(model(ta, tb, tc, cyc + 1 + W));
    @(negedge clk);
    sa_if.start = 1'b0;
    sa_if.a     = W'($urandom);
    sa_if.b     = W'($urandom);
    sa_if.cin   = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", q.size(), 32'd0);
  endtask

  // Monitor: compare on every done, otherwise results must hold.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sa_if.done) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("sum",          sa_if.sum,  e.s);
          chk("cout",         sa_if.cout, e.co);
          chk("ovf",          sa_if.ovf,  e.ov);
          chk("done_latency", cyc,        e.due);
          chk("busy_in_done", sa_if.busy, 1'b1);
          last_sum  = e.s;
          last_cout = e.co;
          last_ovf  = e.ov;
        end
      end else begin
        chk("sum_hold",  sa_if.sum,  last_sum);
        chk("cout_hold", sa_if.cout, last_cout);
        chk("ovf_hold",  sa_if.ovf,  last_ovf);
      end
    end
  end

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    cyc         = 0;
    last_sum    = '0;
    last_cout   = 1'b0;
    last_ovf    = 1'b0;
    rst_n       = 1'b0;
    sa_if.start = 1'b0;
    sa_if.a     = '0;
    sa_if.b     = '0;
    sa_if.cin   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", sa_if.busy, 1'b0);
    chk("rst_done", sa_if.done, 1'b0);
    chk("rst_sum",  sa_if.sum,  8'h00);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Directed operands
    issue(8'h5A, 8'h33, 1'b0);
    issue(8'hFF, 8'h01, 1'b0);
    issue(8'hFF, 8'hFF, 1'b1);
    issue(8'h80, 8'h80, 1'b0);
    issue(8'h00, 8'h00, 1'b0);
    drain();

    // Start during ADD is ignored
    issue(8'h5A, 8'h33, 1'b0);
    @(negedge clk);
    sa_if.start = 1'b1;
    sa_if.a     = 8'h01;
    sa_if.b     = 8'h01;
    sa_if.cin   = 1'b0;
    @(negedge clk);
    sa_if.start = 1'b0;
    drain();
    repeat (4) @(negedge clk);

    // Reset mid-operation aborts, then a fresh operation
    issue(8'h37, 8'hC4, 1'b1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    last_sum  = '0;
    last_cout = 1'b0;
    last_ovf  = 1'b0;
    @(negedge clk);
    chk("midrst_busy", sa_if.busy, 1'b0);
    chk("midrst_done", sa_if.done, 1'b0);
    chk("midrst_sum",  sa_if.sum,  8'h00);
    chk("midrst_cout", sa_if.cout, 1'b0);
    chk("midrst_ovf",  sa_if.ovf,  1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    issue(8'h0F, 8'h01, 1'b0);
    drain();
    repeat (2) @(negedge clk);

    // start held high for 30 cycles: back-to-back at minimum interval
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      sa_if.start = 1'b1;
      sa_if.a     = W'($urandom);
      sa_if.b     = W'($urandom);
      sa_if.cin   = 1'($urandom);
      if (!sa_if.busy) q.push_back(model(sa_if.a, sa_if.b, sa_if.cin, cyc + 1 + W));
    end
    @(negedge clk);
    sa_if.start = 1'b0;
    drain();

    // Random operands with random idle gaps
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(W'($urandom), W'($urandom), 1'($urandom));
    end
    drain();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_serial_adder

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder: accepts two WIDTH-bit operands plus a carry-in, then adds them LSB-first over WIDTH clock cycles through a single `fulladd` cell and a carry flip-flop. It produces a registered WIDTH-bit sum, carry-out and signed-overflow flag with a one-cycle `done` pulse. It sits directly upstream of the ripple-carry datapath as its area-minimal sequential alternative, driven by a simple start/busy/done handshake.

## Interface
- WIDTH, 8: operand/sum width in bits; legal range WIDTH >= 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A, captured on the accepting edge.
- b  input  WIDTH  operand B, captured on the accepting edge.
- cin  input  1  carry-in, captured on the accepting edge.
- busy  output  1  high in ADD and DONE states.
- done  output  1  one-cycle pulse: result valid.
- sum  output  WIDTH  registered result; holds until the next completion.
- cout  output  1  registered carry out of the MSB.
- ovf  output  1  registered signed overflow, equal to (carry into MSB) XOR cout.

## Operation
- States:
  - IDLE: busy=0, done=0. On start=1, load a_sh=a, b_sh=b, carry=cin, cnt=0, then go to ADD.
  - ADD: each cycle runs fulladd(a_sh[0], b_sh[0], carry) to produce (s, c).
    - a_sh and b_sh shift right by 1. sum_sh = {s, sum_sh[WIDTH-1:1]}. carry=c. cnt=cnt+1.
    - When cnt==WIDTH-2, latch the pre-update carry as msb_cin.
    - When cnt==WIDTH-1, load sum={s, sum_sh[WIDTH-1:1]}, cout=c, ovf=carry^c, then go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- start while in ADD or DONE is ignored. Operands are never re-sampled mid-operation.
- a, b and cin may change freely after the accepting edge.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). cnt width is $clog2(WIDTH).
- sum, cout and ovf change only on the final ADD edge. They stay stable through IDLE and through the whole following operation.

## Timing
- Reset (rst_n=0, any time): state=IDLE; busy, done, sum, cout, ovf, carry, cnt and all shift registers are 0.
- Reset mid-operation aborts the operation. No done pulse is produced and the outputs stay 0.
- Edge 0 samples start=1 in IDLE. Edges 1..WIDTH process bits 0..WIDTH-1.
  - After edge WIDTH, done=1 and the result is valid.
  - After edge WIDTH+1, done=0 and busy=0.
- Start-to-done latency is WIDTH cycles. Minimum issue interval is WIDTH+2 cycles; the next start is accepted at edge WIDTH+2 at the earliest.
- busy rises on the edge after start is accepted and falls on the edge after done.
- start held high continuously issues back-to-back operations at the minimum interval.

## Structure
- Shared package `serial_adder_pkg` holds:
  - State encoding: IDLE=2'b00, ADD=2'b01, DONE=2'b10.
  - Default WIDTH constant.
- Sub-module: exactly one instance of the existing `fulladd` cell, which is the only adder logic.
- Control FSM, counter and shift registers live in `serial_adder` itself.

## Test plan
All scenarios use WIDTH=8.
- a=0x5A, b=0x33, cin=0 -> 8 cycles later done=1, sum=0x8D, cout=0, ovf=1.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1, ovf=0.
- a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, ovf=1. Then a=0x00, b=0x00 -> sum=0x00, cout=0, ovf=0, with the previous sum held until that done.
- start at edge 0 (0x5A+0x33), second start at edge 3 (0x01+0x01) -> single done at edge 8 with sum=0x8D. Second request never executes.
- rst_n pulsed low at edge 4 of an operation -> busy=0, no done, sum=0. A following 0x0F+0x01 gives sum=0x10 after 8 cycles.
- start held high for 30 cycles -> done pulses at edges 8, 18 and 28. busy is low exactly one cycle between operations.
